cmp_run_monitor: RTL and testbench
==================================

// Module: cmp_run_monitor
// PURPOSE
//  Downstream consumer of the 4-bit magnitude comparator flags (A_gt_B/A_eq_B/A_ls_B).
//  Accepts one flag triple per valid/ready handshake and tracks consecutive A>B results.
//  Raises a sticky alarm after RUN_LEN consecutive A>B samples, then backpressures until cleared.
//  Feeds status/interrupt logic; optional per-class event statistics.
// PARAMETERS
//  RUN_LEN  4  consecutive accepted A>B samples that trigger alarm (>=1)
//  CNT_W    8  width of each saturating event counter (EVENT_COUNT_EN only)
//  RUN_W    localparam = $clog2(RUN_LEN+1), width of run_cnt
// PORTS
//  clk        in   1      single clock, all logic posedge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      flag triple valid
//  in_ready   out  1      block can accept; 0 only in ALARM
//  a_gt_b     in   1      comparator A>B flag
//  a_eq_b     in   1      comparator A==B flag
//  a_ls_b     in   1      comparator A<B flag
//  alarm_clr  in   1      clear alarm, run and flag_err (1-cycle pulse or level)
//  alarm      out  1      run of RUN_LEN A>B samples detected (sticky)
//  run_cnt    out  RUN_W  current consecutive A>B count
//  last_class out  2      last accepted class: 00 none/invalid, 01 lt, 10 eq, 11 gt
//  flag_err   out  1      sticky: an accepted triple was not one-hot
//  gt_cnt/eq_cnt/ls_cnt out CNT_W  saturating class counters (EVENT_COUNT_EN only)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, in_ready=1, alarm=0, run_cnt=0, last_class=00,
//   flag_err=0, all counters 0. Reset mid-run/mid-alarm discards everything.
//  Accept = in_valid & in_ready. All outputs registered; effects visible cycle after accept.
//  FSM: IDLE (run_cnt=0), RUN (1..RUN_LEN-1), ALARM.
//   IDLE/RUN, accept gt only: run_cnt+1; if new value == RUN_LEN -> ALARM, else RUN.
//   IDLE/RUN, accept eq only or lt only: run_cnt=0 -> IDLE.
//   IDLE/RUN, accept non-one-hot triple (000, 011, 111, ...): flag_err=1, last_class=00,
//    run_cnt=0 -> IDLE, not counted in any class counter.
//   RUN_LEN==1: single gt accept in IDLE -> ALARM directly.
//   ALARM: alarm=1, in_ready=0, run_cnt holds RUN_LEN; in_valid ignored.
//  alarm_clr (any state) has priority: next cycle IDLE, run_cnt=0, alarm=0, flag_err=0.
//   Sample accepted in same cycle: updates last_class and counters only, not run_cnt.
//  in_ready is combinational from state (1 in IDLE/RUN); rises cycle after alarm_clr.
//  Latency: alarm asserts 1 cycle after the RUN_LEN-th consecutive gt accept.
//  in_valid low cycles do not break a run; only eq/lt/invalid accepts break it.
// CONFIGURATION
//  CMP_RUN_EVENT_COUNT_EN defined: gt_cnt/eq_cnt/ls_cnt present; each +1 per accepted
//   one-hot sample of its class, saturate at 2^CNT_W-1, cleared only by reset.
//  Undefined: counter ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Package cmp_mon_pkg: state encoding (ST_IDLE/ST_RUN/ST_ALARM), class codes
//   (CLS_NONE=2'b00, CLS_LT=2'b01, CLS_EQ=2'b10, CLS_GT=2'b11).
//  Sub-module sat_counter #(W): enable, sync active-low reset, saturate at all-ones;
//   instantiated 3x under CMP_RUN_EVENT_COUNT_EN.
// TESTING
//  Reset: hold rst_n=0 with in_valid=1, gt=1 -> all outputs at reset values, in_ready=1.
//  4 gt accepts (RUN_LEN=4) -> run_cnt 1,2,3,4; alarm=1, in_ready=0 after 4th; extra valid ignored.
//  gt,gt,eq,gt -> run_cnt 1,2,0,1; last_class 11,11,10,11; alarm stays 0.
//  Triple 3'b110 accepted mid-run -> flag_err=1, run_cnt=0, last_class=00; alarm_clr -> flag_err=0.
//  In ALARM assert alarm_clr -> next cycle alarm=0, run_cnt=0, in_ready=1; reset mid-ALARM same.
//  CMP_RUN_EVENT_COUNT_EN, CNT_W=2: 5 lt accepts -> ls_cnt 1,2,3,3,3; gt_cnt/eq_cnt stay 0.

Source files
------------

// File: rtl/cmp_mon_pkg.sv
// cmp_mon_pkg: state encoding, class codes and flag-triple classifier for cmp_run_monitor
package cmp_mon_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ALARM} state_t;
  typedef logic [1:0] cls_t;
  localparam cls_t CLS_NONE = 2'b00;
  localparam cls_t CLS_LT = 2'b01;
  localparam cls_t CLS_EQ = 2'b10;
  localparam cls_t CLS_GT = 2'b11;
  // anything other than exactly one flag set is classed as NONE
  function automatic cls_t cls_of(input logic gt, input logic eq, input logic ls);
    return {gt, eq, ls} == 3'b100 ? CLS_GT :
           {gt, eq, ls} == 3'b010 ? CLS_EQ :
           {gt, eq, ls} == 3'b001 ? CLS_LT : CLS_NONE;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with enable that sticks at all-ones
// ports: clk, rst_n (sync active-low), en (count), cnt (value)
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/cmp_run_monitor.sv
// cmp_run_monitor: counts consecutive A>B comparator results and raises a sticky alarm
// ports: clk, rst_n (sync active-low); in_valid/in_ready handshake with a_gt_b/a_eq_b/a_ls_b;
//   alarm_clr clears alarm/run/flag_err; outputs alarm, run_cnt, last_class, flag_err;
//   gt_cnt/eq_cnt/ls_cnt class counters only when CMP_RUN_EVENT_COUNT_EN is defined
module cmp_run_monitor
  import cmp_mon_pkg::*;
#(
  parameter int RUN_LEN = 4,
  parameter int CNT_W = 8,
  localparam int RUN_W = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_gt_b,
  input  logic             a_eq_b,
  input  logic             a_ls_b,
  input  logic             alarm_clr,
  output logic             alarm,
  output logic [RUN_W-1:0] run_cnt,
`ifdef CMP_RUN_EVENT_COUNT_EN
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] ls_cnt,
`endif
  output logic [1:0]       last_class,
  output logic             flag_err
);
  state_t st;
  cls_t cls;
  logic acc;
  logic [RUN_W-1:0] nxt;
  assign in_ready = st != ST_ALARM;
  assign acc = in_valid & in_ready;
  assign cls = cls_of(a_gt_b, a_eq_b, a_ls_b);
  assign nxt = run_cnt + RUN_W'(1);
  // a sample accepted alongside alarm_clr still updates last_class, but the clear owns the run state
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= ST_IDLE;
      alarm <= 1'b0;
      run_cnt <= '0;
      last_class <= CLS_NONE;
      flag_err <= 1'b0;
    end else begin
      if (acc) last_class <= cls;
      if (alarm_clr) begin
        st <= ST_IDLE;
        alarm <= 1'b0;
        run_cnt <= '0;
        flag_err <= 1'b0;
      end else if (acc && cls == CLS_GT) begin
        run_cnt <= nxt;
        st <= nxt == RUN_W'(RUN_LEN) ? ST_ALARM : ST_RUN;
        alarm <= nxt == RUN_W'(RUN_LEN);
      end else if (acc) begin
        run_cnt <= '0;
        st <= ST_IDLE;
        if (cls == CLS_NONE) flag_err <= 1'b1;
      end
    end
`ifdef CMP_RUN_EVENT_COUNT_EN
  sat_counter #(.W(CNT_W)) u_gt (.clk(clk), .rst_n(rst_n), .en(acc && cls == CLS_GT), .cnt(gt_cnt));
  sat_counter #(.W(CNT_W)) u_eq (.clk(clk), .rst_n(rst_n), .en(acc && cls == CLS_EQ), .cnt(eq_cnt));
  sat_counter #(.W(CNT_W)) u_ls (.clk(clk), .rst_n(rst_n), .en(acc && cls == CLS_LT), .cnt(ls_cnt));
`endif
endmodule

// File: tb/tb_cmp_run_monitor.sv
// tb_cmp_run_monitor: directed vector table plus corner sequences for cmp_run_monitor (RUN_LEN=4)
module tb_cmp_run_monitor;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, a_gt_b, a_eq_b, a_ls_b, alarm_clr, alarm, flag_err;
  logic [2:0] run_cnt;
  logic [1:0] last_class;
`ifdef CMP_RUN_EVENT_COUNT_EN
  logic [1:0] gt_cnt, eq_cnt, ls_cnt;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  cmp_run_monitor #(
    .RUN_LEN(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_gt_b(a_gt_b),
    .a_eq_b(a_eq_b),
    .a_ls_b(a_ls_b),
    .alarm_clr(alarm_clr),
    .alarm(alarm),
    .run_cnt(run_cnt),
`ifdef CMP_RUN_EVENT_COUNT_EN
    .gt_cnt(gt_cnt),
    .eq_cnt(eq_cnt),
    .ls_cnt(ls_cnt),
`endif
    .last_class(last_class),
    .flag_err(flag_err)
  );
  // inputs {rst_n, in_valid, gt, eq, ls, clr}; expected outputs after the following edge
  typedef struct {
    logic [5:0] in;
    logic rdy;
    logic alm;
    int run;
    logic [1:0] cls;
    logic err;
  } vec_t;
  vec_t tv[26];
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(input logic [5:0] in);
    {rst_n, in_valid, a_gt_b, a_eq_b, a_ls_b, alarm_clr} = in;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0]  = '{6'b011000, 1, 0, 0, 2'b00, 0};
    tv[1]  = '{6'b011000, 1, 0, 0, 2'b00, 0};
    tv[2]  = '{6'b111000, 1, 0, 1, 2'b11, 0};
    tv[3]  = '{6'b111000, 1, 0, 2, 2'b11, 0};
    tv[4]  = '{6'b111000, 1, 0, 3, 2'b11, 0};
    tv[5]  = '{6'b101000, 1, 0, 3, 2'b11, 0};
    tv[6]  = '{6'b111000, 0, 1, 4, 2'b11, 0};
    tv[7]  = '{6'b110100, 0, 1, 4, 2'b11, 0};
    tv[8]  = '{6'b100001, 1, 0, 0, 2'b11, 0};
    tv[9]  = '{6'b111000, 1, 0, 1, 2'b11, 0};
    tv[10] = '{6'b111000, 1, 0, 2, 2'b11, 0};
    tv[11] = '{6'b110100, 1, 0, 0, 2'b10, 0};
    tv[12] = '{6'b111000, 1, 0, 1, 2'b11, 0};
    tv[13] = '{6'b111000, 1, 0, 2, 2'b11, 0};
    tv[14] = '{6'b111100, 1, 0, 0, 2'b00, 1};
    tv[15] = '{6'b110010, 1, 0, 0, 2'b01, 1};
    tv[16] = '{6'b100001, 1, 0, 0, 2'b01, 0};
    tv[17] = '{6'b111000, 1, 0, 1, 2'b11, 0};
    tv[18] = '{6'b111000, 1, 0, 2, 2'b11, 0};
    tv[19] = '{6'b111000, 1, 0, 3, 2'b11, 0};
    tv[20] = '{6'b111000, 0, 1, 4, 2'b11, 0};
    tv[21] = '{6'b011000, 1, 0, 0, 2'b00, 0};
    tv[22] = '{6'b111000, 1, 0, 1, 2'b11, 0};
    tv[23] = '{6'b111001, 1, 0, 0, 2'b11, 0};
    tv[24] = '{6'b110000, 1, 0, 0, 2'b00, 1};
    tv[25] = '{6'b110011, 1, 0, 0, 2'b01, 0};
    drive(6'b011000);
    #2;
    for (int i = 0; i < 26; i++) begin
      drive(tv[i].in);
      step();
      chk($sformatf("v%0d in_ready", i), int'(in_ready), int'(tv[i].rdy));
      chk($sformatf("v%0d alarm", i), int'(alarm), int'(tv[i].alm));
      chk($sformatf("v%0d run_cnt", i), int'(run_cnt), tv[i].run);
      chk($sformatf("v%0d last_class", i), int'(last_class), int'(tv[i].cls));
      chk($sformatf("v%0d flag_err", i), int'(flag_err), int'(tv[i].err));
    end
    // bounded wait for the alarm under continuous gt, then check it holds off further input
    drive(6'b011000);
    step();
    drive(6'b111000);
    begin
      int c;
      c = 0;
      while (!alarm && c < 10) begin
        step();
        c++;
      end
      chk("alarm latency", c, 4);
    end
    step();
    step();
    chk("alarm hold ready", int'(in_ready), 0);
    chk("alarm hold run", int'(run_cnt), 4);
    drive(6'b011000);
    step();
    chk("rst mid alarm", int'(alarm), 0);
    chk("rst mid alarm ready", int'(in_ready), 1);
    chk("rst mid alarm run", int'(run_cnt), 0);
`ifdef CMP_RUN_EVENT_COUNT_EN
    drive(6'b110010);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("ls_cnt %0d", i), int'(ls_cnt), i > 3 ? 3 : i);
      chk($sformatf("gt_cnt %0d", i), int'(gt_cnt), 0);
      chk($sformatf("eq_cnt %0d", i), int'(eq_cnt), 0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
